// File: rtl/apb_arb_pkg.sv
// apb_req_arbiter shared definitions.
// State encoding and default widths.
package apb_arb_pkg;

    localparam int NUM_REQ_D = 4;
    localparam int ADDR_W_D  = 4;
    localparam int DATA_W_D  = 8;
    localparam int TIMEOUT_D = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches from i_ptr upward, modulo N, for the first set request.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int i = 0; i < N; i++) begin
            w_j = (int'(i_ptr) + i) % N;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = IW'(w_j);
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ requesters.
// Latches the winner's command in IDLE; a watchdog ends stalled transfers.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_D,
    parameter int ADDR_width = ADDR_W_D,
    parameter int DATA_width = DATA_W_D,
    parameter int TIMEOUT    = TIMEOUT_D
) (
    input  logic                       P_clk,
    input  logic                       P_reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [NUM_REQ*ADDR_width-1:0] req_addr,
    input  logic [NUM_REQ*DATA_width-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic [DATA_width-1:0]      req_rdata,
    output logic                       start_transfer,
    output logic                       rw,
    output logic [ADDR_width-1:0]      addr,
    output logic [DATA_width-1:0]      wdata,
    input  logic                       busy,
    input  logic                       valid,
    input  logic [DATA_width-1:0]      rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_t r_state;
    arb_state_t w_next;

    logic [NUM_REQ-1:0]    r_gnt;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_ptr;
    logic                  r_rw;
    logic [ADDR_width-1:0] r_addr;
    logic [DATA_width-1:0] r_wdata;
    logic [DATA_width-1:0] r_rdata;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;

    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_any;
    logic                  w_timeout;
    logic                  w_unused;

    // busy is not part of sequencing
    assign w_unused = busy;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_any)
    );

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (valid || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge P_clk or negedge P_reset_n) begin
        if (!P_reset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick_gnt;
                        r_idx   <= w_pick_idx;
                        r_rw    <= req_rw[w_pick_idx];
                        r_addr  <= req_addr[w_pick_idx*ADDR_width +: ADDR_width];
                        r_wdata <= req_wdata[w_pick_idx*DATA_width +: DATA_width];
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    // valid takes priority over a coincident timeout
                    if (valid) begin
                        if (!r_rw) r_rdata <= rdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_ptr   <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                    r_gnt   <= '0;
                    r_rw    <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign gnt            = r_gnt;
    assign done           = (r_state == DONE) ? r_gnt : '0;
    assign err            = r_err;
    assign req_rdata      = r_rdata;
    assign start_transfer = (r_state == ISSUE);
    assign rw             = r_rw;
    assign addr           = r_addr;
    assign wdata          = r_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Testbench for apb_req_arbiter.
// Behavioural APB master plus scoreboard of expected completions.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_rw = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          err;
    logic [DW-1:0] req_rdata;
    logic          start_transfer;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] rdata = '0;

    apb_req_arbiter #(
        .NUM_REQ    (N),
        .ADDR_width (AW),
        .DATA_width (DW),
        .TIMEOUT    (TO)
    ) dut (
        .P_clk          (clk),
        .P_reset_n      (rst_n),
        .req            (req),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .done           (done),
        .err            (err),
        .req_rdata      (req_rdata),
        .start_transfer (start_transfer),
        .rw             (rw),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .valid          (valid),
        .rdata          (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            e;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            st_cyc = 0;
    int            v_cyc = 0;
    bit            prev_st = 1'b0;
    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] last_rd = '0;

    // master model state
    logic [DW-1:0] mem [16];
    bit            m_act = 1'b0;
    bit            m_stub = 1'b0;
    int            m_lat = 0;
    bit            m_rw = 1'b0;
    logic [AW-1:0] m_a = '0;
    logic [DW-1:0] m_d = '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // master responds two cycles into WAIT; stub mode never completes
    always begin
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (!rst_n) begin
            m_act = 1'b0;
            busy  = 1'b0;
        end else if (m_act) begin
            if (m_lat == 0) begin
                if (!m_stub) begin
                    valid = 1'b1;
                    busy  = 1'b0;
                    m_act = 1'b0;
                    if (m_rw) mem[m_a] = m_d;
                    else rdata = mem[m_a];
                end
            end else begin
                m_lat--;
            end
        end else if (start_transfer) begin
            m_act = 1'b1;
            m_lat = 1;
            busy  = 1'b1;
            m_rw  = rw;
            m_a   = addr;
            m_d   = wdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            if (valid) v_cyc = cyc;
            if (start_transfer) begin
                st_cyc = cyc;
                check("st_pulse", 32'(prev_st), 32'd0);
                if (sb.size() == 0) begin
                    check("st_unexpected", 32'(start_transfer), 32'd0);
                end else begin
                    check("st_gnt", gnt, 32'd1 << sb[0].idx);
                    check("st_rw", rw, sb[0].w);
                    check("st_addr", addr, sb[0].a);
                    if (sb[0].w) check("st_wdata", wdata, sb[0].d);
                end
            end
            if (|done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", done, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_vec", done, 32'd1 << e.idx);
                    check("done_gnt", gnt, 32'd1 << e.idx);
                    check("done_err", err, e.e);
                    check("done_rdata", req_rdata, e.rd);
                    if (e.e) check("to_lat", cyc - st_cyc, TO + 1);
                    else check("v_lat", cyc - v_cyc, 1);
                    req[e.idx] = 1'b0;
                end
            end else begin
                check("err_idle", err, 32'd0);
            end
            prev_st = start_transfer;
        end
    end

    task automatic push(input int i, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit e);
        exp_t x;
        if (!e && !w) last_rd = model_mem[a];
        if (!e && w) model_mem[a] = d;
        x.idx = i; x.w = w; x.a = a; x.d = d; x.e = e; x.rd = last_rd;
        sb.push_back(x);
    endtask

    task automatic drive(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req_rw[i]          = w;
        req_addr[i*AW+:AW] = a;
        req_wdata[i*DW+:DW] = d;
        req[i]             = 1'b1;
    endtask

    task automatic wait_empty(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("sb_drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int i, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit e);
        push(i, w, a, d, e);
        drive(i, w, a, d);
        wait_empty(200);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_gnt"}, gnt, 32'd0);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_err"}, err, 32'd0);
        check({tag, "_rdata"}, req_rdata, 32'd0);
        check({tag, "_st"}, start_transfer, 32'd0);
        check({tag, "_cmd"}, {rw, addr, wdata}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 16; i++) begin
            mem[i]       = '0;
            model_mem[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single write then read back from another requester
        xfer(0, 1'b1, 4'hA, 8'h55, 1'b0);
        xfer(1, 1'b0, 4'hA, 8'h00, 1'b0);

        // contention from reset: 0,1,2,3 then 0 again
        do_reset();
        for (int i = 0; i < N; i++)
            push(i, 1'b1, AW'(i + 1), DW'(8'h11 * (i + 1)), 1'b0);
        push(0, 1'b1, 4'h5, 8'h66, 1'b0);
        for (int i = 0; i < N; i++)
            drive(i, 1'b1, AW'(i + 1), DW'(8'h11 * (i + 1)));
        k = 0;
        while (!done[0] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("c_done0", done[0], 32'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 4'h5, 8'h66);
        wait_empty(400);

        // pointer wrap: grant 3, then 0 and 3 together -> 0 first
        xfer(3, 1'b0, 4'h3, 8'h00, 1'b0);
        push(0, 1'b0, 4'h1, 8'h00, 1'b0);
        push(3, 1'b1, 4'h7, 8'h77, 1'b0);
        drive(0, 1'b0, 4'h1, 8'h00);
        drive(3, 1'b1, 4'h7, 8'h77);
        wait_empty(200);

        // back-to-back reads after writes
        xfer(0, 1'b1, 4'hA, 8'h55, 1'b0);
        xfer(1, 1'b1, 4'hB, 8'h56, 1'b0);
        xfer(2, 1'b0, 4'hA, 8'h00, 1'b0);
        xfer(3, 1'b0, 4'hB, 8'h00, 1'b0);
        xfer(0, 1'b0, 4'hA, 8'h00, 1'b0);

        // timeout with a silent master, then a stray valid in IDLE
        m_stub = 1'b1;
        xfer(1, 1'b0, 4'h2, 8'h00, 1'b1);
        m_act  = 1'b0;
        busy   = 1'b0;
        m_stub = 1'b0;
        @(negedge clk);
        #1;
        rdata = 8'hEE;
        valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_done", done, 32'd0);
            check("late_gnt", gnt, 32'd0);
            check("late_rdata", req_rdata, last_rd);
        end

        // reset during WAIT with req[2] pending
        m_stub = 1'b1;
        push(1, 1'b0, 4'hA, 8'h00, 1'b1);
        drive(1, 1'b0, 4'hA, 8'h00);
        k = 0;
        while (!start_transfer && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rw_issue", start_transfer, 32'd1);
        repeat (4) @(negedge clk);
        drive(2, 1'b0, 4'hB, 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("rwait");
        sb.delete();
        last_rd = '0;
        req[1]  = 1'b0;
        m_act   = 1'b0;
        busy    = 1'b0;
        m_stub  = 1'b0;
        push(2, 1'b0, 4'hB, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_empty(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
